lat_return_buf: RTL and testbench

//   Receiving end of a fixed-latency pipe (e.g. sprite ROM read, fed through dff_delay-style stages).

---
 rtl/lat_return_buf.sv | 101 ++++++++++
 tb/tb_lat_return_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lat_return_buf.sv
// Return buffer for a fixed-latency pipe: credit-gated launch plus a FWFT FIFO.
// Define LAT_RETURN_BUF_CHECK_EN to enable launch/return protocol checking on err_o.
module lat_return_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic                  launch_o,
    input  logic                  ret_valid_i,
    input  logic [DATA_WIDTH-1:0] ret_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]         cnt;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic dec;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign req_ready_o = (cnt < CW'(DEPTH));
    assign launch_o    = req_valid_i && req_ready_o;

    assign out_valid_o = !empty;
    assign out_data_o  = mem[rd_ptr[AW-1:0]];

    assign push = ret_valid_i && !full;
    assign pop  = !empty && out_ready_i;
    // Stray returns after a reset can pop words that hold no credit.
    assign dec  = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (launch_o && !dec) begin
                cnt <= cnt + 1'b1;
            end else if (!launch_o && dec) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr[AW-1:0]] <= ret_data_i;
        end
    end

`ifdef LAT_RETURN_BUF_CHECK_EN
    logic [LATENCY-1:0] launch_sr;
    logic               err;

    always_ff @(posedge clk) begin
        if (rst) begin
            launch_sr <= '0;
            err       <= 1'b0;
        end else begin
            launch_sr[0] <= launch_o;
            for (int i = 1; i < LATENCY; i++) begin
                launch_sr[i] <= launch_sr[i-1];
            end
            if ((ret_valid_i != launch_sr[LATENCY-1]) ||
                (ret_valid_i && full)) begin
                err <= 1'b1;
            end
        end
    end

    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lat_return_buf.sv
// Randomised and directed bench for lat_return_buf against a queue-based model.
// The bench also plays the role of the pipe, returning launched words LATENCY cycles later.
module tb_lat_return_buf;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          launch;
    logic          ret_valid = 1'b0;
    logic [DW-1:0] ret_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          err;

    lat_return_buf #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .launch_o   (launch),
        .ret_valid_i(ret_valid),
        .ret_data_i (ret_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int            m_cnt = 0;
    logic [DW-1:0] m_q[$];
    bit            m_err = 1'b0;
    bit            pipe_v[LAT];
    logic [DW-1:0] pipe_d[LAT];
    logic [DW-1:0] seq = '0;

    // observation
    int            cyc = 0;
    bit            obs_launch;
    bit            obs_ready;
    bit            obs_valid;
    int            first_launch = -1;
    int            first_ov = -1;
    logic [DW-1:0] outq[$];
    bit            rec = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rv, input bit ordy,
                        input bit inj);
        bit            ml;
        bit            pop;
        bit            push;
        bit            full;
        bit            rvl;
        logic [DW-1:0] rd;
        @(negedge clk);
        rvl = pipe_v[LAT-1] | inj;
        rd  = inj ? 8'hEE : pipe_d[LAT-1];
        rst       = r;
        req_valid = rv;
        out_ready = ordy;
        ret_valid = rvl;
        ret_data  = rd;
        #1;
        ml = rv && (m_cnt < DEP);
        check("req_ready", req_ready, m_cnt < DEP);
        check("launch", launch, ml);
        check("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
`ifdef LAT_RETURN_BUF_CHECK_EN
        check("err", err, m_err);
`else
        check("err", err, 1'b0);
`endif
        obs_launch = launch;
        obs_ready  = req_ready;
        obs_valid  = out_valid;
        if (rec) begin
            if (launch && first_launch < 0) first_launch = cyc;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && ordy) outq.push_back(out_data);
        end
        if (r) begin
            m_cnt = 0;
            m_q.delete();
            m_err = 1'b0;
            for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
        end else begin
            full = (m_q.size() == DEP);
            pop  = (m_q.size() > 0) && ordy;
            push = rvl && !full;
            if ((rvl != pipe_v[LAT-1]) || (rvl && full)) m_err = 1'b1;
            if (pop) begin
                void'(m_q.pop_front());
                if (m_cnt > 0) m_cnt--;
            end
            if (ml) m_cnt++;
            if (push) m_q.push_back(rd);
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = ml;
            pipe_d[0] = seq;
            if (ml) seq++;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int n;
        logic [DW-1:0] ev;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end

        // reset with a pending request
        step(1, 1, 0, 0);
        check("rst_launch_comb", obs_launch, 1'b1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("rst_out_valid", obs_valid, 1'b0);
        check("rst_req_ready", obs_ready, 1'b1);
        check("rst_err", err, 1'b0);

        // streaming 0x10..0x17
        seq = 8'h10;
        rec = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0);
            n += obs_launch;
        end
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        rec = 1'b0;
        check("stream_launches", n, 8);
        check("stream_latency", first_ov - first_launch, 3);
        check("stream_count", outq.size(), 8);
        ev = 8'h10;
        foreach (outq[i]) begin
            check("stream_word", outq[i], ev);
            ev++;
        end

        // stall until credits run out
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            n += obs_launch;
        end
        check("stall_launches", n, 4);
        check("stall_ready", obs_ready, 1'b0);
        check("stall_full_valid", obs_valid, 1'b1);
        step(0, 1, 1, 0);
        check("pop_no_launch", obs_launch, 1'b0);
        step(0, 1, 0, 0);
        check("after_pop_ready", obs_ready, 1'b1);
        check("after_pop_launch", obs_launch, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        check("drained", obs_valid, 1'b0);

        // two buffered words, then push+pop+launch together
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

        // reset with returns still in flight
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("midrst_empty", obs_valid, 1'b0);
            check("midrst_ready", obs_ready, 1'b1);
        end

        // stray return with no launch behind it
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
`ifdef LAT_RETURN_BUF_CHECK_EN
        check("stray_err", err, 1'b1);
`else
        check("stray_err", err, 1'b0);
`endif
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("err_cleared", err, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0, $urandom_range(3) != 0,
                 $urandom_range(1) == 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
